// File: rtl/ibuf_axis_rd_pkg.sv
// Shared definitions for the packet-buffer AXIS reader: FSM encoding and buffer word layout.
// Word layout is {tdata, tkeep[TDW/8-1:1], tlast}; tkeep bit 0 is implied by tval.
package ibuf_axis_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int TLAST_BIT = 0;
    localparam int TKEEP_LSB = 1;

    function automatic int calc_dw(input int tdw);
        return tdw + tdw / 8;
    endfunction

    function automatic int tkeep_msb(input int tdw);
        return tdw / 8 - 1;
    endfunction

    function automatic int tdata_lsb(input int tdw);
        return tdw / 8;
    endfunction

endpackage

// File: rtl/ibuf_axis_rd_fifo.sv
// Small output FIFO for the buffer reader; registered storage, head visible combinationally.
// Latency 1 cycle push-to-head; caller must never push when full nor pop when empty.
module ibuf_axis_rd_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [W-1:0]  in_dat,
    input  logic          out_rdy,
    output logic [W-1:0]  out_dat,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop = out_rdy && (cnt_q != '0);
        mem_d  = mem_q;
        if (in_vld) begin
            mem_d[wptr_q] = in_dat;
        end
        wptr_d = in_vld ? nxt(wptr_q) : wptr_q;
        rptr_d = do_pop ? nxt(rptr_q) : rptr_q;
        cnt_d  = cnt_q + CW'(in_vld) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_dat = mem_q[rptr_q];
    assign cnt     = cnt_q;

endmodule

// File: rtl/ibuf_axis_rd.sv
// Reads committed frames from a packet buffer onto AXIS; first beat RL+1 cycles after data commits.
// Backpressure via trdy: read credits (RL+2) stall issue so no returning word is dropped. Option: IBUF_AXIS_RD_FRMCNT_EN.
module ibuf_axis_rd
    import ibuf_axis_rd_pkg::*;
#(
    parameter int  AW  = 10,
    parameter int  TDW = 64,
    parameter int  RL  = 1,
    localparam int DW  = calc_dw(TDW)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [TDW-1:0]   tdat,
    output logic [TDW/8-1:0] tkep,
    output logic             tval,
    output logic             tlst,
    input  logic             trdy,
    input  logic [AW:0]      committed_prod,
    output logic [AW:0]      committed_cons,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_en,
    input  logic [DW-1:0]    rd_data
`ifdef IBUF_AXIS_RD_FRMCNT_EN
    ,
    output logic [31:0]      frm_cnt
`endif
);

    localparam int DEPTH = RL + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SW    = CW + 1;
    localparam int KM    = tkeep_msb(TDW);
    localparam int DL    = tdata_lsb(TDW);

    logic [AW:0]   iptr_q, iptr_d;
    logic [AW:0]   cons_q, cons_d;
    logic [AW:0]   ccons_q, ccons_d;
    logic [RL-1:0] pipe_q, pipe_d;
    logic          en_q;
    state_t        state_q;

    logic [AW:0]   avail;
    logic [CW-1:0] fifo_cnt;
    logic [SW-1:0] inflight, sum, sum_next;
    logic          issue, push, pop, credit_ok;
    logic [DW-1:0] head;

    assign tval = (fifo_cnt != '0);

    // Credits count words in the read pipe plus words parked in the FIFO; a pop in
    // the same cycle is deliberately not credited until the next cycle.
    always_comb begin
        avail    = committed_prod - iptr_q;
        inflight = '0;
        for (int i = 0; i < RL; i++) begin
            inflight = inflight + SW'(pipe_q[i]);
        end
        sum       = inflight + SW'(fifo_cnt);
        credit_ok = (sum < SW'(DEPTH));
        issue     = en_q && (state_q != ST_HOLD) && (avail != '0) && credit_ok;
        push      = pipe_q[RL-1];
        pop       = tval && trdy;
        sum_next  = sum + SW'(issue) - SW'(pop);

        pipe_d[0] = issue;
        for (int i = 1; i < RL; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        iptr_d  = iptr_q + (AW+1)'(issue);
        cons_d  = cons_q + (AW+1)'(pop);
        ccons_d = (pop && tlst) ? cons_q + 1'b1 : ccons_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iptr_q  <= '0;
            cons_q  <= '0;
            ccons_q <= '0;
            pipe_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            iptr_q  <= iptr_d;
            cons_q  <= cons_d;
            ccons_q <= ccons_d;
            pipe_q  <= pipe_d;
            en_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (avail != '0) state_q <= ST_RUN;
                ST_RUN: begin
                    if (sum_next == SW'(DEPTH)) begin
                        state_q <= ST_HOLD;
                    end else if ((avail == '0) && (sum_next == '0)) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: if (pop) state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ibuf_axis_rd_fifo #(
        .W     (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (push),
        .in_dat  (rd_data),
        .out_rdy (pop),
        .out_dat (head),
        .cnt     (fifo_cnt)
    );

    assign tdat           = head[DW-1:DL];
    assign tkep           = {head[KM:TKEEP_LSB], tval};
    assign tlst           = head[TLAST_BIT];
    assign rd_en          = issue;
    assign rd_addr        = iptr_q[AW-1:0];
    assign committed_cons = ccons_q;

`ifdef IBUF_AXIS_RD_FRMCNT_EN
    logic [31:0] frm_q, frm_d;

    always_comb begin
        frm_d = frm_q + 32'(pop && tlst);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_q <= '0;
        end else begin
            frm_q <= frm_d;
        end
    end

    assign frm_cnt = frm_q;
`endif

endmodule

// File: tb/tb_ibuf_axis_rd.sv
// Bench for ibuf_axis_rd: lane A (AW=4, RL=1) and lane B (AW=6, RL=3) against a frame-queue model.
module tb_ibuf_axis_rd;

    logic clk;
    logic rst = 1'b1;
    logic trdy_a, trdy_b;
    logic rnd_a, rnd_b, log_en;

    wire [63:0] tdat_a, tdat_b;
    wire [7:0]  tkep_a, tkep_b;
    wire        tval_a, tval_b, tlst_a, tlst_b, rd_en_a, rd_en_b;
    wire [3:0]  addr_a;
    wire [5:0]  addr_b;
    wire [4:0]  cc_a;
    wire [6:0]  cc_b;
    logic [4:0] prod_a;
    logic [6:0] prod_b;
`ifdef IBUF_AXIS_RD_FRMCNT_EN
    wire [31:0] frm_a, frm_b;
`endif

    logic [71:0] mem_a [16];
    logic [71:0] mem_b [64];
    logic [71:0] rpa, rpb0, rpb1, rpb2;

    logic [71:0] qa[$];
    logic [71:0] qb[$];
    logic [3:0]  alog[$];
    int prod[2];
    int acc[2];
    int exp_cc[2];
    int frames[2];
    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ibuf_axis_rd #(.AW(4), .TDW(64), .RL(1)) u_a (
        .clk(clk), .rst(rst), .tdat(tdat_a), .tkep(tkep_a), .tval(tval_a), .tlst(tlst_a),
        .trdy(trdy_a), .committed_prod(prod_a), .committed_cons(cc_a), .rd_addr(addr_a),
        .rd_en(rd_en_a), .rd_data(rpa)
`ifdef IBUF_AXIS_RD_FRMCNT_EN
        , .frm_cnt(frm_a)
`endif
    );

    ibuf_axis_rd #(.AW(6), .TDW(64), .RL(3)) u_b (
        .clk(clk), .rst(rst), .tdat(tdat_b), .tkep(tkep_b), .tval(tval_b), .tlst(tlst_b),
        .trdy(trdy_b), .committed_prod(prod_b), .committed_cons(cc_b), .rd_addr(addr_b),
        .rd_en(rd_en_b), .rd_data(rpb2)
`ifdef IBUF_AXIS_RD_FRMCNT_EN
        , .frm_cnt(frm_b)
`endif
    );

    // Synchronous buffer memories with 1 and 3 cycles of read latency.
    always @(posedge clk) begin
        rpa  <= mem_a[addr_a];
        rpb0 <= mem_b[addr_b];
        rpb1 <= rpb0;
        rpb2 <= rpb1;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input int l);
        return (l == 0) ? 16 : 64;
    endfunction

    function automatic int cc_dut(input int l);
        return (l == 0) ? int'(cc_a) : int'(cc_b);
    endfunction

    function automatic int qlen(input int l);
        return (l == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic tval_of(input int l);
        return (l == 0) ? tval_a : tval_b;
    endfunction

    task automatic mon(input int l);
        logic        tv, tl, rdy;
        logic [63:0] td;
        logic [7:0]  tk;
        logic [6:0]  ccv;
        logic [71:0] w;
        if (l == 0) begin
            tv = tval_a; td = tdat_a; tk = tkep_a; tl = tlst_a; ccv = {2'b00, cc_a}; rdy = trdy_a;
        end else begin
            tv = tval_b; td = tdat_b; tk = tkep_b; tl = tlst_b; ccv = cc_b; rdy = trdy_b;
        end
        chk(l == 0 ? "a_committed_cons" : "b_committed_cons", 72'(ccv), 72'(exp_cc[l]));
        if (tv) begin
            if (qlen(l) == 0) begin
                chk(l == 0 ? "a_extra_beat" : "b_extra_beat", 72'(tv), 72'(0));
            end else begin
                w = (l == 0) ? qa[0] : qb[0];
                chk(l == 0 ? "a_tdat" : "b_tdat", 72'(td), 72'(w[71:8]));
                chk(l == 0 ? "a_tkep" : "b_tkep", 72'(tk), 72'({w[7:1], 1'b1}));
                chk(l == 0 ? "a_tlst" : "b_tlst", 72'(tl), 72'(w[0]));
                if (rdy) begin
                    if (l == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                    acc[l] = (acc[l] + 1) % (2 * sz(l));
                    if (w[0]) begin
                        exp_cc[l] = acc[l];
                        frames[l]++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon(0);
            mon(1);
            if (log_en && rd_en_a) alog.push_back(addr_a);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_a) trdy_a = 1'($urandom_range(0, 1));
        if (rnd_b) trdy_b = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input int l, input int len);
        int n = 0;
        int idx;
        logic [71:0] w;
        while ((sz(l) - ((prod[l] - cc_dut(l) + 2 * sz(l)) % (2 * sz(l)))) < len && n < 5000) begin
            tick();
            n++;
        end
        chk("space_wait_in_budget", 72'(n < 5000), 72'(1));
        for (int k = 0; k < len; k++) begin
            w   = {$urandom, $urandom, 7'($urandom), 1'(k == len - 1)};
            idx = (prod[l] + k) % sz(l);
            if (l == 0) begin mem_a[idx] = w; qa.push_back(w); end
            else        begin mem_b[idx] = w; qb.push_back(w); end
        end
        prod[l] = (prod[l] + len) % (2 * sz(l));
        if (l == 0) prod_a = 5'(prod[l]);
        else        prod_b = 7'(prod[l]);
    endtask

    task automatic wait_drain(input int l, input int budget);
        int n = 0;
        while (!(qlen(l) == 0 && exp_cc[l] == prod[l]) && n < budget) begin
            tick();
            n++;
        end
        chk(l == 0 ? "a_drain_in_budget" : "b_drain_in_budget", 72'(n < budget), 72'(1));
    endtask

    // Leaves the caller at the negedge where the first beat is seen.
    task automatic measure_lat(input int l, input int rl);
        int k = 0;
        @(negedge clk);
        while (!tval_of(l) && k < 20) begin
            k++;
            @(negedge clk);
        end
        checks++;
        assert (k <= rl + 1) else begin
            errors++;
            $error("FAIL first_tval_latency observed %0d cycles required <= %0d", k, rl + 1);
        end
    endtask

    task automatic chk_zero(input int l);
        if (l == 0) begin
            chk("a_rst_tval", 72'(tval_a), 0);   chk("a_rst_tdat", 72'(tdat_a), 0);
            chk("a_rst_tkep", 72'(tkep_a), 0);   chk("a_rst_tlst", 72'(tlst_a), 0);
            chk("a_rst_rd_en", 72'(rd_en_a), 0); chk("a_rst_rd_addr", 72'(addr_a), 0);
            chk("a_rst_cons", 72'(cc_a), 0);
        end else begin
            chk("b_rst_tval", 72'(tval_b), 0);   chk("b_rst_tdat", 72'(tdat_b), 0);
            chk("b_rst_tkep", 72'(tkep_b), 0);   chk("b_rst_tlst", 72'(tlst_b), 0);
            chk("b_rst_rd_en", 72'(rd_en_b), 0); chk("b_rst_rd_addr", 72'(addr_b), 0);
            chk("b_rst_cons", 72'(cc_b), 0);
        end
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        for (int l = 0; l < 2; l++) begin
            prod[l] = 0; acc[l] = 0; exp_cc[l] = 0; frames[l] = 0;
        end
        prod_a = '0;
        prod_b = '0;
    endtask

    initial begin
        int n;
        int c;
        trdy_a = 1'b0; trdy_b = 1'b0;
        rnd_a = 1'b0; rnd_b = 1'b0; log_en = 1'b0;
        clear_model();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        rst = 1'b1;
        tick(); tick();

        // Single 8-word frame, trdy held high.
        trdy_a = 1'b1; trdy_b = 1'b1;
        send_frame(0, 8);
        measure_lat(0, 1);
        wait_drain(0, 200);
        chk("a_cons_after_frame8", 72'(cc_a), 72'(8));

        // Frame spanning words 12..19 wraps the 16-word buffer.
        send_frame(0, 4);
        wait_drain(0, 200);
        alog.delete();
        log_en = 1'b1;
        send_frame(0, 8);
        wait_drain(0, 200);
        log_en = 1'b0;
        chk("a_wrap_read_count", 72'(alog.size()), 72'(8));
        for (int j = 0; j < 8; j++) begin
            if (j < alog.size()) chk("a_wrap_rd_addr", 72'(alog[j]), 72'((12 + j) % 16));
        end
        chk("a_cons_after_wrap", 72'(cc_a), 72'(20));

        // Random backpressure, frames 1/9/17 and a few random lengths.
        rnd_b = 1'b1;
        send_frame(1, 1);
        send_frame(1, 9);
        send_frame(1, 17);
        for (int j = 0; j < 5; j++) send_frame(1, $urandom_range(1, 24));
        wait_drain(1, 4000);
        rnd_b = 1'b0; trdy_b = 1'b1;

        rnd_a = 1'b1;
        send_frame(0, 1);
        send_frame(0, 16);
        send_frame(0, 1);
        send_frame(0, 5);
        wait_drain(0, 3000);
        rnd_a = 1'b0; trdy_a = 1'b1;

        // RL=3 lane: a 64-word jump must stream without bubbles.
        tick();
        send_frame(1, 64);
        measure_lat(1, 3);
        c = tval_b ? 1 : 0;
        for (int j = 1; j < 64; j++) begin
            @(negedge clk);
            if (tval_b) c++;
        end
        chk("b_tval_cycles_in_64", 72'(c), 72'(64));
        wait_drain(1, 300);
        chk("b_cons_after_burst", 72'(cc_b), 72'(prod[1]));

        // Reset while beat 3 of a 10-word frame is on the bus.
        tick();
        n = acc[0];
        send_frame(0, 10);
        c = 0;
        while (acc[0] != (n + 2) % 32 && c < 200) begin
            tick();
            c++;
        end
        chk("a_reach_beat3", 72'(c < 200), 72'(1));
        rst = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        clear_model();
        repeat (3) tick();
        rst = 1'b1;
        repeat (12) tick();

        rnd_a = 1'b1;
        send_frame(0, 1);
        send_frame(0, 3);
        send_frame(0, 2);
        send_frame(0, 7);
        send_frame(0, 4);
        wait_drain(0, 2000);
        rnd_a = 1'b0; trdy_a = 1'b1;
        send_frame(1, 3);
        wait_drain(1, 300);
        chk("a_frames_after_reset", 72'(frames[0]), 72'(5));
`ifdef IBUF_AXIS_RD_FRMCNT_EN
        chk("a_frm_cnt", 72'(frm_a), 72'(frames[0]));
        chk("b_frm_cnt", 72'(frm_b), 72'(frames[1]));
`endif
        chk("a_cons_final", 72'(cc_a), 72'(17));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibuf_axis_rd.md
IBUF_AXIS_RD -- requirements
Module: ibuf_axis_rd

Interface
REQ-001 SHALL have parameter AW, default 10: buffer address width; the buffer holds 2^AW words.
REQ-002 SHALL have parameter TDW, default 64: AXIS data width, a multiple of 64 (64, 128, 256).
REQ-003 SHALL have parameter RL, default 1: buffer read latency in cycles, from rd_addr/rd_en to rd_data (range 1..3).
REQ-004 SHALL have derived constant DW = TDW + TDW/8: buffer word width; layout {tdata[TDW-1:0], tkeep[TDW/8-1:1], tlast}.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 tdat  out  TDW  AXIS data.
REQ-008 tkep  out  TDW/8  AXIS keep; bit0 is always 1 while tval is 1.
REQ-009 tval  out  1  AXIS valid.
REQ-010 tlst  out  1  AXIS last.
REQ-011 trdy  in  1  AXIS ready.
REQ-012 committed_prod  in  AW+1  producer pointer; advances only at frame ends.
REQ-013 committed_cons  out  AW+1  consumer pointer; word index following the last fully accepted frame.
REQ-014 rd_addr  out  AW  buffer read address.
REQ-015 rd_en  out  1  buffer read strobe.
REQ-016 rd_data  in  DW  buffer read data, valid RL cycles after rd_en.

Function
REQ-017 SHALL keep a (AW+1)-bit issue pointer iptr; rd_addr = iptr[AW-1:0]; all pointer arithmetic SHALL be modulo 2^(AW+1).
REQ-018 SHALL define avail = committed_prod - iptr; avail = 2^AW means full buffer, 0 means empty.
REQ-019 SHALL assert rd_en and increment iptr in a cycle only when avail != 0 and inflight + fifo_cnt < RL+2.
REQ-020 SHALL push each rd_data into an output FIFO of depth RL+2 exactly RL cycles after its rd_en; no push is ever dropped.
REQ-021 SHALL drive tval = (fifo_cnt != 0), with tdat/tkep/tlst taken from the FIFO head; tkep = {word tkeep field, 1'b1}.
REQ-022 Handshake: a word is consumed when tval && trdy are both 1; tdat/tkep/tlst SHALL hold stable while tval=1 and trdy=0.
REQ-023 SHALL sustain one word per cycle with trdy held at 1; first tval SHALL be at most RL+1 cycles after avail becomes non-zero.
REQ-024 SHALL count accepted words in cons (AW+1 bits); on acceptance of a tlst=1 word, committed_cons SHALL become cons+1 on the next cycle.
REQ-025 FSM states: IDLE (avail=0, FIFO and pipeline empty), RUN (issuing reads), HOLD (credits exhausted). Transitions: IDLE->RUN when avail!=0; RUN->HOLD when the credit limit is reached; HOLD->RUN on a pop; RUN->IDLE when avail=0 and the FIFO drains.
REQ-026 Simultaneous push and pop SHALL leave fifo_cnt unchanged; simultaneous issue and pop SHALL keep the credit count exact.
REQ-027 Wrap: reads SHALL continue across address 2^AW-1 -> 0 with no bubble.
REQ-028 A frame of one word (tlst=1 in the first word) SHALL be handled identically to longer frames.

Reset
REQ-029 On rst=0: tval=0, tdat=0, tkep=0, tlst=0, rd_en=0, rd_addr=0, committed_cons=0, iptr=cons=0, FIFO and pipeline emptied, FSM=IDLE.
REQ-030 Reset mid-frame SHALL discard all partially read data; the producer is reset in the same domain.

Configuration
REQ-031 With IBUF_AXIS_RD_FRMCNT_EN defined, the block SHALL add output frm_cnt[31:0], reset to 0, incremented on each accepted tlst word, wrapping at 2^32.
REQ-032 Without IBUF_AXIS_RD_FRMCNT_EN, the frm_cnt port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the DW derivation function, and the word field offsets (tlast bit 0, tkeep bits, data MSBs).
REQ-034 The output FIFO SHALL be a sub-module ibuf_axis_rd_fifo, parametrised by width and depth.

Verification
REQ-035 Single 64-byte frame, TDW=64, RL=1, trdy=1: prod 0->8 -> 8 beats, tlst on beat 8, committed_cons=8 one cycle after.
REQ-036 Random trdy (50%), 3 frames of 1/9/17 words: data matches in order, no duplicated or lost beats, and data holds stable while stalled.
REQ-037 Wrap: AW=4, frame occupying words 12..19 -> rd_addr sequence 12..15,0..3, committed_cons=20.
REQ-038 RL=3, trdy=1, prod jumps by 64 -> 64 consecutive tval cycles with no bubbles after the first beat.
REQ-039 rst=0 asserted at beat 3 of a 10-word frame -> all outputs 0 within the same cycle, and after release no stale beats appear.
REQ-040 With IBUF_AXIS_RD_FRMCNT_EN, 5 frames -> frm_cnt=5; without the macro, the port is absent and the build compiles.
